// File: rtl/loader_pkg.sv
// ============================================================================
// Module      : loader_pkg
// Description : Shared types, constants and sizing helpers for the UART
//               program loader and its byte receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package loader_pkg;

   // First byte of every image frame
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Load sequencer states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } load_state_t;

   // Receiver bit-level states
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // Oversampling divider: round(clk_hz / (baud*16)), never below 1
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + baud * 8) / (baud * 16);
      return (d < 1) ? 1 : d;
   endfunction

   // Bits needed to count 0..n-1, at least 1
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART byte receiver. Two-flop synchroniser, 16x
//               oversampling tick, mid-bit start re-check and data sampling.
//               Emits a one-cycle byte_valid or frame_err at mid-stop-bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int DIV = 27
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int DIV_W = cnt_width(DIV);

   logic             rx_meta;
   logic             rx_sync;
   logic             rx_prev;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   rx_state_t        state;
   logic [3:0]       os_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;

   // Synchronise the line and keep one older sample for falling-edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Free-running divider producing the 16x oversampling tick
   always_ff @(posedge clk) begin
      if (rst || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);
   end

   assign tick = (div_cnt == DIV_W'(DIV - 1));

   // Bit FSM; start needs a falling edge so a held-low line after a bad
   // stop bit is not mistaken for a fresh start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RX_IDLE;
         os_cnt     <= 4'd0;
         bit_idx    <= 3'd0;
         shift      <= 8'h00;
         byte_data  <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  state  <= RX_START;
                  os_cnt <= 4'd0;
               end
            end
            RX_START: begin
               if (tick) begin
                  if (os_cnt == 4'd7) begin
                     os_cnt  <= 4'd0;
                     bit_idx <= 3'd0;
                     state   <= rx_sync ? RX_IDLE : RX_DATA;
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  if (os_cnt == 4'd15) begin
                     os_cnt <= 4'd0;
                     shift  <= {rx_sync, shift[7:1]};
                     if (bit_idx == 3'd7) state <= RX_STOP;
                     else                 bit_idx <= bit_idx + 3'd1;
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  if (os_cnt == 4'd15) begin
                     os_cnt <= 4'd0;
                     state  <= RX_IDLE;
                     if (rx_sync) begin
                        byte_valid <= 1'b1;
                        byte_data  <= shift;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     os_cnt <= os_cnt + 4'd1;
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_program_loader.sv
// ============================================================================
// Module      : uart_program_loader
// Description : Boot loader. Receives a framed image (A5, N lo, N hi, N
//               little-endian words, optional checksum) over UART, writes
//               it into instruction memory and holds the core in reset
//               until a complete, valid image has been accepted.
//               Optional feature macro: LOADER_CHECKSUM_EN (trailing
//               mod-256 sum byte of the payload is checked).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_program_loader
   import loader_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int ITCM_WORDS = 1024
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic        imem_we,
   output logic [11:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        done,
   output logic        error
);

   localparam int DIV   = calc_div(CLK_HZ, BAUD);
   localparam int IDX_W = cnt_width(ITCM_WORDS);

   logic             byte_valid;
   logic             frame_err;
   logic [7:0]       rx_byte;
   load_state_t      state;
   logic [7:0]       len_lo;
   logic [15:0]      len;
   logic [15:0]      len_req;
   logic [IDX_W-1:0] index;
   logic [1:0]       byte_cnt;
   logic [23:0]      word_buf;
   logic             last_word;

   uart_rx_byte #(
      .DIV (DIV)
   ) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (uart_rx),
      .byte_valid (byte_valid),
      .byte_data  (rx_byte),
      .frame_err  (frame_err)
   );

   assign len_req   = {rx_byte, len_lo};
   assign last_word = (16'(index) == (len - 16'd1));

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] csum;

   // Running mod-256 sum of payload bytes, cleared when the length is taken
   always_ff @(posedge clk) begin
      if (rst)                                   csum <= 8'h00;
      else if (byte_valid && state == ST_LEN_HI) csum <= 8'h00;
      else if (byte_valid && state == ST_DATA)   csum <= csum + rx_byte;
   end
`endif

   // Load sequencer, word assembler and registered memory/core outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         len_lo     <= 8'h00;
         len        <= 16'h0000;
         index      <= '0;
         byte_cnt   <= 2'd0;
         word_buf   <= 24'h000000;
         imem_we    <= 1'b0;
         imem_addr  <= 12'h000;
         imem_wdata <= 32'h00000000;
         core_hold  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         imem_we <= 1'b0;
         if (frame_err && state != ST_IDLE && state != ST_DONE) begin
            state <= ST_ERROR;
            error <= 1'b1;
         end else if (byte_valid) begin
            case (state)
               ST_IDLE: begin
                  if (rx_byte == SYNC_BYTE) state <= ST_LEN_LO;
               end
               ST_LEN_LO: begin
                  len_lo <= rx_byte;
                  state  <= ST_LEN_HI;
               end
               ST_LEN_HI: begin
                  len      <= len_req;
                  index    <= '0;
                  byte_cnt <= 2'd0;
                  if (len_req == 16'd0 || len_req > 16'(ITCM_WORDS)) begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end else begin
                     state <= ST_DATA;
                  end
               end
               ST_DATA: begin
                  if (byte_cnt == 2'd3) begin
                     imem_we    <= 1'b1;
                     imem_addr  <= 12'({index, 2'b00});
                     imem_wdata <= {rx_byte, word_buf};
                     byte_cnt   <= 2'd0;
                     if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state <= ST_CSUM;
`else
                        state     <= ST_DONE;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
`endif
                     end else begin
                        index <= index + IDX_W'(1);
                     end
                  end else begin
                     word_buf <= {rx_byte, word_buf[23:8]};
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               ST_CSUM: begin
                  if (rx_byte == csum) begin
                     state     <= ST_DONE;
                     core_hold <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
`endif
               ST_ERROR: begin
                  if (rx_byte == SYNC_BYTE) begin
                     error <= 1'b0;
                     state <= ST_LEN_LO;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_program_loader.sv
// ============================================================================
// Module      : tb_uart_program_loader
// Description : Self-checking bench for uart_program_loader. Serialises
//               directed and random images onto uart_rx and compares the
//               observed memory writes and status against expectations
//               built from the frame format. Honours LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_program_loader;

   localparam int CLK_HZ     = 3200000;
   localparam int BAUD       = 100000;
   localparam int ITCM_WORDS = 1024;
   localparam int BIT_CLKS   = CLK_HZ / BAUD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rx = 1'b1;
   logic        imem_we;
   logic [11:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_hold;
   logic        done;
   logic        error;

   int n_total = 0;
   int n_pass  = 0;
   int bv_count = 0;

   logic [43:0] wr_q[$];
   logic [43:0] exp_q[$];
   logic [7:0]  tx_q[$];
   logic [31:0] img[$];

   logic prev_we   = 1'b0;
   logic prev_bv   = 1'b0;
   logic prev_hold = 1'b1;

   always #5 clk = ~clk;

   uart_program_loader #(
      .CLK_HZ     (CLK_HZ),
      .BAUD       (BAUD),
      .ITCM_WORDS (ITCM_WORDS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .done       (done),
      .error      (error)
   );

   // Write logger plus pulse-timing checks, sampled mid-cycle
   always @(negedge clk) begin
      if (imem_we) begin
         wr_q.push_back({imem_addr, imem_wdata});
         n_total++;
         assert ((!prev_we && prev_bv && imem_addr[1:0] == 2'b00 &&
                  imem_addr <= 12'((ITCM_WORDS - 1) * 4)) === 1'b1) n_pass++;
         else $error("FAIL we_timing: prev_we=%0b prev_bv=%0b addr=%h, required single pulse right after byte_valid, aligned, in range",
                     prev_we, prev_bv, imem_addr);
      end
      if (prev_hold && !core_hold) begin
         n_total++;
         assert ((prev_bv && done) === 1'b1) n_pass++;
         else $error("FAIL hold_release: prev_bv=%0b done=%0b, required 1/1", prev_bv, done);
      end
      if (dut.u_rx.byte_valid) bv_count++;
      prev_we   = imem_we;
      prev_bv   = dut.u_rx.byte_valid;
      prev_hold = core_hold;
   end

   // Hard stop so the bench can never hang
   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_log(input string tag);
      int n;
      n = exp_q.size();
      check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(n));
      for (int i = 0; i < n; i++)
         if (i < wr_q.size()) check($sformatf("%s_wr%0d", tag, i), 64'(wr_q[i]), 64'(exp_q[i]));
      wr_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_we"},    64'(imem_we),    64'(0));
      check({tag, "_addr"},  64'(imem_addr),  64'(0));
      check({tag, "_wdata"}, 64'(imem_wdata), 64'(0));
      check({tag, "_hold"},  64'(core_hold),  64'(1));
      check({tag, "_done"},  64'(done),       64'(0));
      check({tag, "_error"}, 64'(error),      64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      uart_rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      uart_rx = stop_ok;
      repeat (BIT_CLKS) @(negedge clk);
      uart_rx = 1'b1;
      if (!stop_ok) repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_q();
      while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
      repeat (4) @(negedge clk);
   endtask

   // Frame the words in img; optionally record the writes they should cause
   task automatic queue_image(input bit expect_writes);
      int n;
      logic [31:0] w;
      logic [15:0] n16;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] sum;
      sum = 8'h00;
`endif
      n   = img.size();
      n16 = 16'(n);
      tx_q.push_back(8'hA5);
      tx_q.push_back(n16[7:0]);
      tx_q.push_back(n16[15:8]);
      for (int i = 0; i < n; i++) begin
         w = img[i];
         for (int k = 0; k < 4; k++) begin
            tx_q.push_back(w[8*k +: 8]);
`ifdef LOADER_CHECKSUM_EN
            sum = sum + w[8*k +: 8];
`endif
         end
         if (expect_writes) exp_q.push_back({12'(i * 4), w});
      end
`ifdef LOADER_CHECKSUM_EN
      tx_q.push_back(sum);
`endif
   endtask

   task automatic random_image(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
   endtask

   task automatic check_loaded(input string tag);
      check({tag, "_done"},  64'(done),      64'(1));
      check({tag, "_hold"},  64'(core_hold), 64'(0));
      check({tag, "_error"}, 64'(error),     64'(0));
      check_log(tag);
   endtask

   initial begin
      int bv0;
      logic [7:0] junk;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);

      // Short low glitch in IDLE must not decode a byte
      bv0 = bv_count;
      uart_rx = 1'b0;
      repeat ((BIT_CLKS * 3 + 5) / 10) @(negedge clk);
      uart_rx = 1'b1;
      repeat (BIT_CLKS * 3) @(negedge clk);
      check("glitch_no_byte", 64'(bv_count), 64'(bv0));
      check("glitch_error", 64'(error), 64'(0));

      // Stray byte, then the reference 2-word image
      tx_q.push_back(8'h55);
      img.delete();
      img.push_back(32'h00000013);
      img.push_back(32'h00100093);
      queue_image(1'b0);
      exp_q.push_back({12'h000, 32'h00000013});
      exp_q.push_back({12'h004, 32'h00100093});
      send_q();
      check_loaded("basic");

      // After done, further traffic is ignored
      random_image(1);
      queue_image(1'b0);
      send_q();
      check("post_done_done", 64'(done), 64'(1));
      check_log("post_done");

      // Length 0 and ITCM_WORDS+1 are rejected; ITCM_WORDS is accepted
      do_reset();
      tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
      send_q();
      check("len0_error", 64'(error), 64'(1));
      check("len0_hold", 64'(core_hold), 64'(1));
      tx_q.push_back(8'hA5);
      send_q();
      check("retry_clears_error", 64'(error), 64'(0));
      tx_q.push_back(8'h01); tx_q.push_back(8'h04);
      send_q();
      check("len_over_error", 64'(error), 64'(1));
      check("len_over_done", 64'(done), 64'(0));
      tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h04);
      send_q();
      check("len_max_ok", 64'(error), 64'(0));
      check_log("len_bounds");

`ifdef LOADER_CHECKSUM_EN
      // Wrong checksum fails, correct one succeeds
      do_reset();
      img.delete();
      img.push_back(32'h00000013);
      queue_image(1'b1);
      tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] ^ 8'h07;
      send_q();
      check("csum_bad_error", 64'(error), 64'(1));
      check("csum_bad_done", 64'(done), 64'(0));
      check_log("csum_bad");
      queue_image(1'b1);
      send_q();
      check_loaded("csum_good");
`endif

      // Framing error on the 3rd data byte, then a clean image
      do_reset();
      tx_q.push_back(8'hA5); tx_q.push_back(8'h01); tx_q.push_back(8'h00);
      tx_q.push_back(8'h13); tx_q.push_back(8'h00);
      send_q();
      send_byte(8'h00, 1'b0);
      repeat (4) @(negedge clk);
      check("frame_error", 64'(error), 64'(1));
      check("frame_hold", 64'(core_hold), 64'(1));
      check_log("frame");
      random_image(2);
      queue_image(1'b1);
      send_q();
      check_loaded("frame_retry");

      // Reset after 6 payload bytes of a 2-word image
      do_reset();
      random_image(2);
      queue_image(1'b0);
      exp_q.push_back({12'h000, img[0]});
      for (int i = 0; i < 9; i++) send_byte(tx_q.pop_front(), 1'b1);
      repeat (4) @(negedge clk);
      check_log("pre_abort");
      tx_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("abort");
      repeat (BIT_CLKS * 4) @(negedge clk);
      check_log("abort_quiet");
      random_image(2);
      queue_image(1'b1);
      send_q();
      check_loaded("abort_reload");

      // Random images with random leading junk
      for (int it = 0; it < 3; it++) begin
         do_reset();
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            tx_q.push_back(junk);
         end
         random_image(int'($urandom_range(1, 4)));
         queue_image(1'b1);
         send_q();
         check_loaded($sformatf("rand%0d", it));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
